// File: rtl/cam_dvp_emitter.sv
// cam_dvp_emitter: OV7670-style DVP byte-stream source producing RGB565 test
// frames (vsync / href / 8-bit data, two bytes per pixel, one byte per clk).
// Next state and next outputs are computed together so that every output is a
// register that changes on the same edge as the FSM state.
module cam_dvp_emitter #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic        busy
);

    localparam int          LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam logic [15:0] COL_LAST = 16'(LINE_LEN - 1);
    localparam logic [15:0] HREF_END = 16'(2 * H_ACTIVE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] col_q, col_d;
    logic [15:0] line_q, line_d;
    logic [1:0]  pat_q, pat_d;
    logic [15:0] solid_q, solid_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic        frame_end;
    logic [14:0] x_w;
    int          bar_idx;
    logic [15:0] pix_word;

    // Number of lines spent in each non-idle state.
    function automatic logic [15:0] lines_in(input state_t s);
        case (s)
            S_VSYNC:  lines_in = 16'(VSYNC_LINES);
            S_VBACK:  lines_in = 16'(V_BACK);
            S_ACTIVE: lines_in = 16'(V_ACTIVE);
            S_VFRONT: lines_in = 16'(V_FRONT);
            default:  lines_in = 16'd0;
        endcase
    endfunction

    // Next-state: column/line counters, state sequencing with zero-length
    // states skipped, and pattern latching on every entry to VSYNC.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        line_d    = line_q;
        pat_d     = pat_q;
        solid_d   = solid_q;
        frame_end = 1'b0;
        if (state_q == S_IDLE) begin
            if (enable) begin
                state_d = S_VSYNC;
                col_d   = 16'd0;
                line_d  = 16'd0;
                pat_d   = pattern_sel;
                solid_d = solid_rgb;
            end
        end else if (col_q != COL_LAST) begin
            col_d = col_q + 16'd1;
        end else begin
            col_d = 16'd0;
            if (line_q != lines_in(state_q) - 16'd1) begin
                line_d = line_q + 16'd1;
            end else begin
                line_d = 16'd0;
                case (state_q)
                    S_VSYNC: begin
                        if (V_BACK > 0) state_d = S_VBACK;
                        else            state_d = S_ACTIVE;
                    end
                    S_VBACK: state_d = S_ACTIVE;
                    S_ACTIVE: begin
                        if (V_FRONT > 0) state_d = S_VFRONT;
                        else             frame_end = 1'b1;
                    end
                    default: frame_end = 1'b1;
                endcase
                // Back-to-back frames re-latch the pattern with no gap.
                if (frame_end) begin
                    if (enable) begin
                        state_d = S_VSYNC;
                        pat_d   = pattern_sel;
                        solid_d = solid_rgb;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        end
    end

    // Output decode from the next state, so outputs line up with the state.
    always_comb begin
        x_w      = col_d[15:1];
        bar_idx  = (int'(x_w) * 8) / H_ACTIVE;
        pix_word = 16'h0000;
        case (pat_d)
            2'd0: begin
                case (bar_idx)
                    0:       pix_word = 16'hFFFF;
                    1:       pix_word = 16'hFFE0;
                    2:       pix_word = 16'h07FF;
                    3:       pix_word = 16'h07E0;
                    4:       pix_word = 16'hF81F;
                    5:       pix_word = 16'hF800;
                    6:       pix_word = 16'h001F;
                    default: pix_word = 16'h0000;
                endcase
            end
            2'd1:    pix_word = {x_w[4:0], x_w[5:0], line_d[4:0]};
            2'd2:    pix_word = {line_d[7:0], x_w[7:0]};
            default: pix_word = solid_d;
        endcase
        vsync_d = (state_d == S_VSYNC);
        href_d  = (state_d == S_ACTIVE) && (col_d < HREF_END);
        data_d  = 8'h00;
        if (href_d) begin
            data_d = col_d[0] ? pix_word[7:0] : pix_word[15:8];
        end
        done_d = ((state_d == S_VFRONT) && (line_d == 16'(V_FRONT - 1)) &&
                  (col_d == COL_LAST)) ||
                 ((V_FRONT == 0) && (state_d == S_ACTIVE) &&
                  (line_d == 16'(V_ACTIVE - 1)) && (col_d == COL_LAST));
        busy_d = (state_d != S_IDLE);
    end

    // State, counters, latched pattern and all outputs; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= 16'd0;
            line_q  <= 16'd0;
            pat_q   <= 2'd0;
            solid_q <= 16'd0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            pat_q   <= pat_d;
            solid_q <= solid_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign cam_vsync  = vsync_q;
    assign cam_href   = href_q;
    assign cam_data   = data_q;
    assign frame_done = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cam_dvp_emitter.sv
// tb_cam_dvp_emitter: directed sequence of frames with randomized pattern and
// solid-colour values, every cycle compared against a frame-position model.
module tb_cam_dvp_emitter;

    localparam int HA = 8;
    localparam int VA = 4;
    localparam int HB = 4;
    localparam int VS = 1;
    localparam int VB = 2;
    localparam int VF = 1;
    localparam int L  = 2 * HA + HB;
    localparam int F  = (VS + VB + VA + VF) * L;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_rgb;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        frame_done;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    cam_dvp_emitter #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .frame_done(frame_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // Expected {vsync, href, frame_done, data} at cycle k of a frame.
    function automatic logic [10:0] model(input int k, input int pat,
                                          input logic [15:0] solid);
        int line, col, x, y;
        logic vs, hr, fd;
        logic [15:0] w;
        logic [7:0] d;
        line = k / L;
        col  = k % L;
        x    = col / 2;
        y    = line - (VS + VB);
        vs   = (line < VS);
        hr   = (y >= 0) && (y < VA) && (col < 2 * HA);
        w    = 16'h0000;
        if (hr) begin
            case (pat)
                0:       w = bars[(8 * x) / HA];
                1:       w = 16'(((x % 32) << 11) | ((x % 64) << 5) | (y % 32));
                2:       w = 16'(((y % 256) << 8) | (x % 256));
                default: w = solid;
            endcase
        end
        d  = hr ? ((col % 2 == 0) ? w[15:8] : w[7:0]) : 8'h00;
        fd = (k == F - 1);
        return {vs, hr, fd, d};
    endfunction

    // Check ncyc cycles of a frame that starts on the next edge; optionally
    // change the pattern inputs or drop enable after checking a given cycle.
    task automatic run_frame(input int pat, input logic [15:0] solid,
                             input int ncyc, input int chg_at, input int new_pat,
                             input logic [15:0] new_solid, input int drop_at);
        logic [10:0] e;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            e = model(k, pat, solid);
            chk("vsync", k, 16'(cam_vsync), 16'(e[10]));
            chk("href", k, 16'(cam_href), 16'(e[9]));
            chk("frame_done", k, 16'(frame_done), 16'(e[8]));
            chk("data", k, 16'(cam_data), 16'(e[7:0]));
            chk("busy", k, 16'(busy), 16'h0001);
            chk("vsync_href_excl", k, 16'(cam_vsync & cam_href), 16'h0000);
            if (k == chg_at) begin
                pattern_sel = 2'(new_pat);
                solid_rgb   = new_solid;
            end
            if (k == drop_at) enable = 1'b0;
        end
    endtask

    task automatic idle_check(input string tag, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            chk({tag, "_outs"}, k,
                {5'd0, cam_vsync, cam_href, frame_done, cam_data}, 16'h0000);
            chk({tag, "_busy"}, k, 16'(busy), 16'h0000);
        end
    endtask

    initial begin
        int rp, rp2;
        logic [15:0] s1, rs, rs2;
        s1  = 16'($urandom);
        rs  = 16'($urandom);
        rs2 = 16'($urandom);
        rp  = int'($urandom_range(0, 3));
        rp2 = int'($urandom_range(0, 3));

        rst_n       = 1'b0;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        solid_rgb   = 16'h0000;
        idle_check("reset", 3);
        rst_n = 1'b1;
        idle_check("idle_disabled", 3);

        // Coordinate pattern, then colour bars latched at the next frame.
        pattern_sel = 2'd2;
        enable      = 1'b1;
        run_frame(2, 16'h0000, F, 100, 0, 16'h0000, -1);
        run_frame(0, 16'h0000, F, 100, 3, 16'hABCD, -1);
        // Solid colour changed mid-frame only takes effect next frame.
        run_frame(3, 16'hABCD, F, 90, 3, 16'h1234, -1);
        run_frame(3, 16'h1234, F, 100, 1, s1, -1);
        // Three ramp frames; enable dropped during line y=1 of the third.
        run_frame(1, s1, F, -1, 0, 16'h0000, -1);
        run_frame(1, s1, F, -1, 0, 16'h0000, -1);
        run_frame(1, s1, F, -1, 0, 16'h0000, 85);
        idle_check("after_drop", 5);

        // Asynchronous reset in the middle of an active line.
        pattern_sel = 2'(rp);
        solid_rgb   = rs;
        enable      = 1'b1;
        run_frame(rp, rs, 71, -1, 0, 16'h0000, -1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_href", 0, 16'(cam_href), 16'h0000);
        chk("rst_async_data", 0, 16'(cam_data), 16'h0000);
        chk("rst_async_busy", 0, 16'(busy), 16'h0000);
        idle_check("rst_held", 2);
        rst_n = 1'b1;
        run_frame(rp, rs, F, 30, rp2, rs2, -1);
        run_frame(rp2, rs2, F, -1, 0, 16'h0000, 150);
        idle_check("final_idle", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cam_dvp_emitter.md
# cam_dvp_emitter

Synthesizable OV7670-style DVP source: generates `cam_vsync`, `cam_href` and 8-bit `cam_data` carrying RGB565 frames, two bytes per pixel, one byte per `clk`. It stands in for the physical sensor in simulation and in FPGA loopback builds. Its outputs feed the camera receiver, pixel buffer and VGA path with known test patterns.

## Interface
- `H_ACTIVE`, 640: active pixels per line (2..1023).
- `V_ACTIVE`, 480: active lines per frame (1..511).
- `H_BLANK`, 144: byte clocks with `cam_href` low after each line (≥1).
- `VSYNC_LINES`, 3: lines with `cam_vsync` high (≥1).
- `V_BACK`, 17: blank lines after vsync (≥0).
- `V_FRONT`, 10: blank lines after the last active line (≥0).

- `clk` in 1: byte clock; every cycle carries one byte.
- `rst_n` in 1: asynchronous active-low reset.
- `enable` in 1: run frames while high.
- `pattern_sel` in 2: 0 color bars, 1 ramp, 2 coordinate, 3 solid.
- `solid_rgb` in 16: RGB565 word for pattern 3.
- `cam_vsync` out 1: frame sync, active high.
- `cam_href` out 1: line valid, active high.
- `cam_data` out 8: pixel byte; 8'h00 whenever `cam_href`=0.
- `frame_done` out 1: one-cycle pulse on the last cycle of a frame.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Line length L = 2*H_ACTIVE + H_BLANK cycles. Every non-idle line is exactly L cycles.
- FSM states: IDLE → VSYNC (VSYNC_LINES lines) → VBACK (V_BACK lines) → ACTIVE (V_ACTIVE lines) → VFRONT (V_FRONT lines) → VSYNC if `enable`=1, else IDLE. Any state with a zero line count is skipped.
- IDLE: all outputs 0. `enable` is sampled every cycle.
- `pattern_sel` and `solid_rgb` are latched on entry to VSYNC. They are constant for the whole frame.
- `enable` deasserted mid-frame: the current frame completes through VFRONT, then the FSM goes to IDLE. There is no abort.
- ACTIVE line: `cam_href`=1 for the first 2*H_ACTIVE cycles, then 0 for H_BLANK cycles.
- Pixel x = 0..H_ACTIVE-1 and line y = 0..V_ACTIVE-1.
- Pixel word P[15:0]: R=P[15:11], G=P[10:5], B=P[4:0]. Byte order is P[15:8] first, then P[7:0].
- Pattern 0: bar index b = floor(8x/H_ACTIVE). Bar words are FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000 for b = 0..7.
- Pattern 1: R=x[4:0], G=x[5:0], B=y[4:0].
- Pattern 2: P={y[7:0], x[7:0]}.
- Pattern 3: P = latched `solid_rgb`.
- `frame_done` asserts on the final cycle of VFRONT. If V_FRONT=0, it asserts on the final cycle of the last active line.

## Timing
- All outputs are registered. State and outputs update on the same edge.
- IDLE with `enable`=1 at edge N: `cam_vsync`=1 from edge N onward, for VSYNC_LINES*L cycles.
- Frame period F = (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)*L cycles.
- With `enable` held high, `cam_vsync` rises every F cycles with no gap. The cycle after `frame_done` is the first VSYNC cycle.
- `cam_href` rises exactly (VSYNC_LINES+V_BACK)*L cycles after `cam_vsync` rises.
- Pixel x occupies cycles 2x and 2x+1 of its line.
- `cam_vsync` and `cam_href` are never high in the same cycle.
- `rst_n` low at any time: all outputs go to 0 immediately, FSM goes to IDLE, counters clear, and latched pattern registers clear.
- After `rst_n` rises with `enable` already high, the first frame starts at the first `clk` edge.

## Test plan
Common parameters: H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=2, V_FRONT=1, giving L=20 and F=160.

1. Reset, then `enable`=1 with pattern 2 → `cam_vsync` high for 20 cycles, `cam_href` rises 60 cycles after `cam_vsync`. Line 1 bytes are 01,00,01,01,…,01,07. `frame_done` pulses at cycle 159, and `cam_vsync` rises again at cycle 160.
2. Pattern 0 → bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00 on every active line. `cam_data`=00 in every blank cycle.
3. Pattern 3 with `solid_rgb`=ABCD, changed to 1234 mid-frame → AB,CD continues to the end of the frame. The next frame emits 12,34.
4. `enable` dropped during line y=1 → the frame completes with all four active lines. `frame_done` pulses, `busy` falls the next cycle and outputs stay 0.
5. `rst_n` pulsed low mid-active-line → `cam_href`, `cam_data` and `busy` go to 0 asynchronously. After release with `enable`=1, a full 160-cycle frame follows.
6. Pattern 1, checked over 3 back-to-back frames → received pixel words match the ramp formula and `cam_vsync`/`cam_href` are never high together.
